// File: rtl/dram_pkg.sv
// Shared DRAM definitions: field widths, timing defaults, command and scheduler state enums.
package dram_pkg;

    localparam int unsigned BANK_GROUP_BITS = 2;
    localparam int unsigned BANK_BITS       = 2;
    localparam int unsigned ROW_BITS        = 17;
    localparam int unsigned COL_BITS        = 10;
    localparam int unsigned CNT_BITS        = 16;

    localparam int unsigned T_RCD_DEF   = 16;
    localparam int unsigned T_RP_DEF    = 16;
    localparam int unsigned T_CL_DEF    = 16;
    localparam int unsigned T_CWL_DEF   = 12;
    localparam int unsigned T_BURST_DEF = 4;
    localparam int unsigned T_RFC_DEF   = 280;
    localparam int unsigned T_REFI_DEF  = 7800;

    // Command presented to the signal generator
    typedef enum logic [2:0] {
        NOP, ACTIVATE, READ, WRITE, PRECHARGE, REFRESH
    } state_t;

    typedef enum logic [3:0] {
        IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, RW, RW_WAIT, REF, REF_WAIT
    } sched_state_t;

    typedef struct packed {
        logic                       write;
        logic [BANK_GROUP_BITS-1:0] bg;
        logic [BANK_BITS-1:0]       ba;
        logic [ROW_BITS-1:0]        row;
        logic [COL_BITS-1:0]        col;
    } req_t;

    function automatic state_t cmd_of(input sched_state_t s, input logic wr);
        case (s)
            PRE:     return PRECHARGE;
            ACT:     return ACTIVATE;
            RW:      return wr ? WRITE : READ;
            REF:     return REFRESH;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/dram_cmd_sched.sv
// Single-request DRAM command scheduler with one tracked open row and periodic refresh.
module dram_cmd_sched
    import dram_pkg::*;
#(
    parameter int unsigned T_RCD   = T_RCD_DEF,
    parameter int unsigned T_RP    = T_RP_DEF,
    parameter int unsigned T_CL    = T_CL_DEF,
    parameter int unsigned T_CWL   = T_CWL_DEF,
    parameter int unsigned T_BURST = T_BURST_DEF,
    parameter int unsigned T_RFC   = T_RFC_DEF,
    parameter int unsigned T_REFI  = T_REFI_DEF
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       req_valid,
    input  logic                       req_write,
    input  logic [BANK_GROUP_BITS-1:0] req_bg,
    input  logic [BANK_BITS-1:0]       req_ba,
    input  logic [ROW_BITS-1:0]        req_row,
    input  logic [COL_BITS-1:0]        req_col,
    output logic                       req_ready,
    output logic                       done,
    output state_t                     state,
    output state_t                     nstate,
    output logic [BANK_GROUP_BITS-1:0] BG0,
    output logic [BANK_BITS-1:0]       BA0,
    output logic [ROW_BITS-1:0]        R0,
    output logic [COL_BITS-1:0]        C0,
    output logic                       ref_re
);

    // Wait states last tX-1 cycles, so the counter is loaded with tX-2
    localparam logic [CNT_BITS-1:0] RP_LOAD  = CNT_BITS'(T_RP - 2);
    localparam logic [CNT_BITS-1:0] RCD_LOAD = CNT_BITS'(T_RCD - 2);
    localparam logic [CNT_BITS-1:0] RFC_LOAD = CNT_BITS'(T_RFC - 2);
    localparam logic [CNT_BITS-1:0] RD_LOAD  = CNT_BITS'(T_CL + T_BURST - 2);
    localparam logic [CNT_BITS-1:0] WR_LOAD  = CNT_BITS'(T_CWL + T_BURST - 2);
    localparam logic [CNT_BITS-1:0] REFI_END = CNT_BITS'(T_REFI - 1);

    sched_state_t               fsm, fsm_n;
    logic [CNT_BITS-1:0]        cnt, cnt_n;
    req_t                       cur, cur_n;
    logic                       open_valid, open_valid_n;
    logic [BANK_GROUP_BITS-1:0] open_bg, open_bg_n;
    logic [BANK_BITS-1:0]       open_ba, open_ba_n;
    logic [ROW_BITS-1:0]        open_row, open_row_n;
    logic                       ref_seq, ref_seq_n;
    logic                       ref_pending, ref_pending_n;
    logic [CNT_BITS-1:0]        refi_cnt;
    logic                       refi_expire;
    logic                       hit;

    assign hit         = open_valid && (open_bg == req_bg) && (open_ba == req_ba) && (open_row == req_row);
    assign refi_expire = (refi_cnt == REFI_END);
    assign nstate      = NOP;
    assign BG0         = cur.bg;
    assign BA0         = cur.ba;
    assign R0          = cur.row;
    assign C0          = cur.col;

    // Next-state, counter and open-row bookkeeping
    always_comb begin
        fsm_n        = fsm;
        cnt_n        = cnt;
        cur_n        = cur;
        open_valid_n = open_valid;
        open_bg_n    = open_bg;
        open_ba_n    = open_ba;
        open_row_n   = open_row;
        ref_seq_n    = ref_seq;
        case (fsm)
            IDLE: begin
                if (ref_pending) begin
                    ref_seq_n = 1'b1;
                    fsm_n     = open_valid ? PRE : REF;
                end else if (req_valid) begin
                    cur_n.write = req_write;
                    cur_n.bg    = req_bg;
                    cur_n.ba    = req_ba;
                    cur_n.row   = req_row;
                    cur_n.col   = req_col;
                    fsm_n       = hit ? RW : (open_valid ? PRE : ACT);
                end
            end
            PRE: begin
                open_valid_n = 1'b0;
                if (T_RP > 1) begin
                    cnt_n = RP_LOAD;
                    fsm_n = PRE_WAIT;
                end else begin
                    fsm_n = ref_seq ? REF : ACT;
                end
            end
            PRE_WAIT: begin
                if (cnt == '0) fsm_n = ref_seq ? REF : ACT;
                else           cnt_n = cnt - CNT_BITS'(1);
            end
            ACT: begin
                open_valid_n = 1'b1;
                open_bg_n    = cur.bg;
                open_ba_n    = cur.ba;
                open_row_n   = cur.row;
                if (T_RCD > 1) begin
                    cnt_n = RCD_LOAD;
                    fsm_n = ACT_WAIT;
                end else begin
                    fsm_n = RW;
                end
            end
            ACT_WAIT: begin
                if (cnt == '0) fsm_n = RW;
                else           cnt_n = cnt - CNT_BITS'(1);
            end
            RW: begin
                cnt_n = cur.write ? WR_LOAD : RD_LOAD;
                fsm_n = RW_WAIT;
            end
            RW_WAIT: begin
                if (cnt == '0) fsm_n = IDLE;
                else           cnt_n = cnt - CNT_BITS'(1);
            end
            REF: begin
                open_valid_n = 1'b0;
                ref_seq_n    = 1'b0;
                if (T_RFC > 1) begin
                    cnt_n = RFC_LOAD;
                    fsm_n = REF_WAIT;
                end else begin
                    fsm_n = IDLE;
                end
            end
            REF_WAIT: begin
                if (cnt == '0) fsm_n = IDLE;
                else           cnt_n = cnt - CNT_BITS'(1);
            end
            default: fsm_n = IDLE;
        endcase
        // Issuing REF consumes the pending request; a coincident expiry is dropped
        ref_pending_n = (fsm == REF) ? 1'b0 : (refi_expire ? 1'b1 : ref_pending);
    end

    // State register; outputs are registered from the next-state values
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fsm        <= IDLE;
            cnt        <= '0;
            cur        <= '0;
            open_valid <= 1'b0;
            open_bg    <= '0;
            open_ba    <= '0;
            open_row   <= '0;
            ref_seq    <= 1'b0;
            state      <= NOP;
            req_ready  <= 1'b1;
            done       <= 1'b0;
            ref_re     <= 1'b0;
        end else begin
            fsm        <= fsm_n;
            cnt        <= cnt_n;
            cur        <= cur_n;
            open_valid <= open_valid_n;
            open_bg    <= open_bg_n;
            open_ba    <= open_ba_n;
            open_row   <= open_row_n;
            ref_seq    <= ref_seq_n;
            state      <= cmd_of(fsm_n, cur_n.write);
            req_ready  <= (fsm_n == IDLE) && !ref_pending_n;
            done       <= (fsm_n == RW_WAIT) && (cnt_n == '0);
            ref_re     <= (fsm_n == PRE) && ref_seq_n;
        end
    end

    // Free-running refresh interval counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            refi_cnt    <= '0;
            ref_pending <= 1'b0;
        end else begin
            refi_cnt    <= refi_expire ? '0 : refi_cnt + CNT_BITS'(1);
            ref_pending <= ref_pending_n;
        end
    end

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Directed and randomized bench for dram_cmd_sched against a transaction-level schedule model.
module tb_dram_cmd_sched;
    import dram_pkg::*;

    localparam int unsigned T_RCD = 3, T_RP = 2, T_CL = 4, T_CWL = 3;
    localparam int unsigned T_BURST = 2, T_RFC = 6, T_REFI = 40;
    localparam int MAXC = 4096;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic req_valid = 1'b0, req_write = 1'b0;
    logic [BANK_GROUP_BITS-1:0] req_bg = '0;
    logic [BANK_BITS-1:0]       req_ba = '0;
    logic [ROW_BITS-1:0]        req_row = '0;
    logic [COL_BITS-1:0]        req_col = '0;
    logic req_ready, done, ref_re;
    state_t state, nstate;
    logic [BANK_GROUP_BITS-1:0] BG0;
    logic [BANK_BITS-1:0]       BA0;
    logic [ROW_BITS-1:0]        R0;
    logic [COL_BITS-1:0]        C0;

    always #5 CLK = ~CLK;

    dram_cmd_sched #(
        .T_RCD(T_RCD), .T_RP(T_RP), .T_CL(T_CL), .T_CWL(T_CWL),
        .T_BURST(T_BURST), .T_RFC(T_RFC), .T_REFI(T_REFI)
    ) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_write(req_write),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .req_ready(req_ready), .done(done), .state(state), .nstate(nstate),
        .BG0(BG0), .BA0(BA0), .R0(R0), .C0(C0), .ref_re(ref_re)
    );

    int n_checks = 0;
    int n_fail = 0;
    int t = 0;

    // Reference model: commands are scheduled as absolute cycles when a transaction starts
    int idle_at;
    bit m_pend, m_open, accepted;
    int acc_t;
    logic [BANK_GROUP_BITS-1:0] m_bg, x_bg;
    logic [BANK_BITS-1:0]       m_ba, x_ba;
    logic [ROW_BITS-1:0]        m_row, x_row;
    logic [COL_BITS-1:0]        x_col;
    state_t exp_cmd [MAXC];
    bit     exp_rre [MAXC];
    bit     exp_done[MAXC];

    int obs_pre, obs_act, obs_rw, obs_ref, obs_done;
    bit obs_pre_rre;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, t, obs, expv);
        end
    endtask

    function automatic void sched(input int c, input state_t cmd, input bit rre);
        if (c < MAXC) begin
            exp_cmd[c] = cmd;
            exp_rre[c] = rre;
        end
    endfunction

    task automatic model_reset();
        t = 0; idle_at = 0; m_pend = 0; m_open = 0; accepted = 0; acc_t = 0;
        m_bg = '0; m_ba = '0; m_row = '0;
        x_bg = '0; x_ba = '0; x_row = '0; x_col = '0;
        for (int i = 0; i < MAXC; i++) begin
            exp_cmd[i] = NOP; exp_rre[i] = 0; exp_done[i] = 0;
        end
    endtask

    task automatic step(input bit v, input bit w, input logic [BANK_GROUP_BITS-1:0] bg,
                        input logic [BANK_BITS-1:0] ba, input logic [ROW_BITS-1:0] row,
                        input logic [COL_BITS-1:0] col);
        int a, rw, lat;
        if (t >= MAXC - 64) begin
            n_fail++;
            $display("FAIL cycle_budget: observed cycle %0d limit %0d", t, MAXC - 64);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $fatal(1, "cycle budget exhausted");
        end
        if (state == PRECHARGE) begin obs_pre = t; obs_pre_rre = ref_re; end
        if (state == ACTIVATE) obs_act = t;
        if (state == READ || state == WRITE) obs_rw = t;
        if (state == REFRESH) obs_ref = t;
        if (done) obs_done = t;
        check("state",     32'(state),     32'(exp_cmd[t]));
        check("nstate",    32'(nstate),    32'(NOP));
        check("req_ready", 32'(req_ready), 32'(t >= idle_at && !m_pend));
        check("done",      32'(done),      32'(exp_done[t]));
        check("ref_re",    32'(ref_re),    32'(exp_rre[t]));
        check("BG0",       32'(BG0),       32'(x_bg));
        check("BA0",       32'(BA0),       32'(x_ba));
        check("R0",        32'(R0),        32'(x_row));
        check("C0",        32'(C0),        32'(x_col));
        req_valid = v; req_write = w; req_bg = bg; req_ba = ba; req_row = row; req_col = col;
        accepted = 0;
        if (t >= idle_at) begin
            if (m_pend) begin
                a = t + 1;
                if (m_open) begin sched(a, PRECHARGE, 1); a += T_RP; end
                sched(a, REFRESH, 0);
                idle_at = a + T_RFC;
                m_open = 0;
            end else if (v) begin
                accepted = 1; acc_t = t;
                x_bg = bg; x_ba = ba; x_row = row; x_col = col;
                if (m_open && m_bg == bg && m_ba == ba && m_row == row) begin
                    rw = t + 1;
                end else begin
                    a = t + 1;
                    if (m_open) begin sched(a, PRECHARGE, 0); a += T_RP; end
                    sched(a, ACTIVATE, 0);
                    rw = a + T_RCD;
                end
                sched(rw, w ? WRITE : READ, 0);
                lat = w ? T_CWL : T_CL;
                if (rw + lat + T_BURST - 1 < MAXC) exp_done[rw + lat + T_BURST - 1] = 1;
                idle_at = rw + lat + T_BURST;
                m_open = 1; m_bg = bg; m_ba = ba; m_row = row;
            end
        end
        if (exp_cmd[t] == REFRESH) m_pend = 0;
        else if ((t + 1) % T_REFI == 0) m_pend = 1;
        @(posedge CLK); #1;
        t++;
    endtask

    task automatic idle_until_ready();
        int n = 0;
        while (!(t >= idle_at && !m_pend) && n < 200) begin
            step(0, 0, '0, '0, '0, '0);
            n++;
        end
        check("ready_timeout", 32'(t >= idle_at && !m_pend), 32'(1));
    endtask

    task automatic issue(input bit w, input logic [BANK_GROUP_BITS-1:0] bg,
                         input logic [BANK_BITS-1:0] ba, input logic [ROW_BITS-1:0] row,
                         input logic [COL_BITS-1:0] col);
        int n = 0;
        accepted = 0;
        while (!accepted && n < 200) begin
            step(1, w, bg, ba, row, col);
            n++;
        end
        check("accept_timeout", 32'(accepted), 32'(1));
        req_valid = 0;
    endtask

    initial begin
        int saved_act;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_state",  32'(state),     32'(NOP));
        check("rst_nstate", 32'(nstate),    32'(NOP));
        check("rst_done",   32'(done),      32'(0));
        check("rst_ref_re", 32'(ref_re),    32'(0));
        check("rst_R0",     32'(R0),        32'(0));
        check("rst_ready",  32'(req_ready), 32'(1));
        RST = 0;
        model_reset();

        // Read to a closed bank
        issue(0, 2'd1, 2'd2, 17'h155, 10'h20);
        idle_until_ready();
        check("rd_R0", 32'(R0), 32'h155);
        check("rd_C0", 32'(C0), 32'h20);
        check("rd_act_to_read", 32'(obs_rw - obs_act), 32'(3));
        check("rd_read_to_done", 32'(obs_done - obs_rw), 32'(5));

        // Write row hit
        saved_act = obs_act;
        issue(1, 2'd1, 2'd2, 17'h155, 10'h33);
        idle_until_ready();
        check("wr_hit_latency", 32'(obs_rw - acc_t), 32'(1));
        check("wr_hit_no_act", 32'(obs_act), 32'(saved_act));
        check("wr_write_to_done", 32'(obs_done - obs_rw), 32'(4));

        // Row miss
        issue(0, 2'd1, 2'd2, 17'h156, 10'h01);
        idle_until_ready();
        check("miss_pre_ref_re", 32'(obs_pre_rre), 32'(0));
        check("miss_pre_to_act", 32'(obs_act - obs_pre), 32'(2));
        check("miss_act_to_read", 32'(obs_rw - obs_act), 32'(3));

        // Request still in flight at refresh expiry, then one held across the refresh
        issue(0, 2'd1, 2'd2, 17'h157, 10'h02);
        issue(0, 2'd1, 2'd2, 17'h157, 10'h03);
        check("ref_pre_ref_re", 32'(obs_pre_rre), 32'(1));
        check("ref_pre_to_ref", 32'(obs_ref - obs_pre), 32'(2));
        check("ref_to_accept", 32'(acc_t - obs_ref), 32'(6));

        // Reset during ACT_WAIT of the post-refresh request
        step(0, 0, '0, '0, '0, '0);
        check("pre_rst_act", 32'(obs_act), 32'(acc_t + 1));
        RST = 1;
        #1;
        check("rst_mid_state", 32'(state), 32'(NOP));
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check("rst_mid_state_c",  32'(state),     32'(NOP));
            check("rst_mid_nstate_c", 32'(nstate),    32'(NOP));
            check("rst_mid_done",     32'(done),      32'(0));
            check("rst_mid_ready",    32'(req_ready), 32'(1));
        end
        RST = 0;
        model_reset();
        obs_act = -1;
        issue(0, 2'd1, 2'd2, 17'h157, 10'h04);
        idle_until_ready();
        check("post_rst_act", 32'(obs_act), 32'(acc_t + 1));

        // Random traffic over a small address set for hits, misses and refresh overlap
        for (int i = 0; i < 900; i++) begin
            step(($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                 BANK_GROUP_BITS'($urandom_range(0, 1)), BANK_BITS'($urandom_range(0, 1)),
                 ROW_BITS'(17'h10 + $urandom_range(0, 1)), COL_BITS'($urandom));
        end
        idle_until_ready();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
